// File: rtl/fb_mem_sched.sv
// fb_mem_sched: arbitrates the framebuffer memory port between display line
// prefetch (strict priority) and host read/write bursts.
module fb_mem_sched #(
  parameter int unsigned H_ENABLE    = 640,
  parameter int unsigned V_ENABLE    = 1024,
  parameter int unsigned BURST_LEN   = 32,
  parameter int unsigned LINE_STRIDE = 1024,
  parameter int unsigned FB_BASE     = 0,
  parameter int unsigned AW          = 24
) (
  input  logic          xclk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          de,
  input  logic [10:0]   cnt_y,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  output logic          host_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_gnt,
  input  logic          mem_done,
  output logic          disp_sel,
  output logic          line_sel,
  output logic          underrun,
  input  logic          underrun_clr
);

  localparam int unsigned NB = H_ENABLE / BURST_LEN;
  localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  typedef enum logic [2:0] {
    IDLE, D_REQ, D_WAIT, H_REQ, H_WAIT
  } state_t;

  state_t        state, state_nxt;
  logic          vsync_q, de_q;
  logic          frame_trig, line_trig, trig;
  logic [10:0]   fetch_line, line_nxt;
  logic [IW-1:0] burst_idx, idx_nxt;
  logic          pending, pend_nxt;
  logic          restart, restart_nxt;
  logic          und_nxt;
  logic [63:0]   disp_addr;

  assign frame_trig = vsync_q & ~vsync;
  assign line_trig  = de & ~de_q & (cnt_y < 11'(V_ENABLE - 1));
  assign trig       = frame_trig | line_trig;

  // restart marks a burst in flight that belongs to an abandoned line
  always_comb begin
    line_nxt    = fetch_line;
    idx_nxt     = burst_idx;
    pend_nxt    = pending;
    restart_nxt = restart;
    und_nxt     = underrun & ~underrun_clr;
    if (state == D_WAIT && mem_done) begin
      if (restart)
        restart_nxt = 1'b0;
      else if (burst_idx == LAST)
        pend_nxt = 1'b0;
      else
        idx_nxt = burst_idx + 1'b1;
    end
    if (trig) begin
      line_nxt    = frame_trig ? 11'd0 : cnt_y + 11'd1;
      idx_nxt     = '0;
      pend_nxt    = 1'b1;
      restart_nxt = (state == D_REQ) ||
                    (state == D_WAIT && !mem_done);
      if (pending)
        und_nxt = 1'b1;
    end
  end

  assign disp_addr = 64'(FB_BASE)
                   + 64'(line_nxt) * 64'(LINE_STRIDE)
                   + 64'(idx_nxt) * 64'(BURST_LEN);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (pending)       state_nxt = D_REQ;
        else if (host_req) state_nxt = H_REQ;
      D_REQ:
        if (mem_gnt) state_nxt = D_WAIT;
      D_WAIT:
        if (mem_done) state_nxt = pend_nxt ? D_REQ : IDLE;
      H_REQ:
        if (mem_gnt) state_nxt = H_WAIT;
      H_WAIT:
        if (mem_done) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge xclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsync_q    <= 1'b0;
      de_q       <= 1'b1;
      fetch_line <= '0;
      burst_idx  <= '0;
      pending    <= 1'b0;
      restart    <= 1'b0;
      underrun   <= 1'b0;
      host_ack   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      state      <= state_nxt;
      vsync_q    <= vsync;
      de_q       <= de;
      fetch_line <= line_nxt;
      burst_idx  <= idx_nxt;
      pending    <= pend_nxt;
      restart    <= restart_nxt;
      underrun   <= und_nxt;
      host_ack   <= (state == H_WAIT) && mem_done;
      // address/direction are captured on entry so they hold until grant
      if (state_nxt == D_REQ && state != D_REQ) begin
        mem_we   <= 1'b0;
        mem_addr <= disp_addr[AW-1:0];
      end else if (state_nxt == H_REQ && state != H_REQ) begin
        mem_we   <= host_we;
        mem_addr <= host_addr;
      end else if (state_nxt != D_REQ && state_nxt != H_REQ) begin
        mem_we   <= 1'b0;
        mem_addr <= '0;
      end
    end
  end

  assign mem_req  = (state == D_REQ) || (state == H_REQ);
  assign disp_sel = (state == D_REQ) || (state == D_WAIT);
  assign line_sel = fetch_line[0];

endmodule

// File: tb/tb_fb_mem_sched.sv
// tb_fb_mem_sched: directed checks of display prefetch, host arbitration,
// underrun handling and reset for fb_mem_sched.
module tb_fb_mem_sched;

  logic        xclk;
  logic        rst_n;
  logic        vsync;
  logic        de;
  logic [10:0] cnt_y;
  logic        host_req;
  logic        host_we;
  logic [23:0] host_addr;
  logic        host_ack;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic        mem_gnt;
  logic        mem_done;
  logic        md;
  logic        stray;
  logic        disp_sel;
  logic        line_sel;
  logic        underrun;
  logic        underrun_clr;

  typedef struct {
    logic        we;
    logic [23:0] addr;
    logic        disp;
    logic        ls;
  } req_t;

  req_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   done_cyc = 0;
  int   ack_cyc = 0;
  int   ack_cnt = 0;
  int   done_dly = 8;
  logic busy, seen;
  int   cnt;

  assign mem_done = md | stray;

  fb_mem_sched dut (
    .xclk(xclk), .rst_n(rst_n), .vsync(vsync), .de(de),
    .cnt_y(cnt_y), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_ack(host_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_done(mem_done),
    .disp_sel(disp_sel), .line_sel(line_sel),
    .underrun(underrun), .underrun_clr(underrun_clr)
  );

  initial xclk = 1'b0;
  always #5 xclk = ~xclk;

  // memory model: grant one cycle after request, done done_dly later
  always @(negedge xclk) begin
    mem_gnt = 1'b0;
    md      = 1'b0;
    if (!rst_n) begin
      busy = 1'b0;
      seen = 1'b0;
    end else if (busy) begin
      if (cnt == 0) begin
        md   = 1'b1;
        busy = 1'b0;
      end else begin
        cnt = cnt - 1;
      end
    end else if (mem_req) begin
      if (seen) begin
        mem_gnt = 1'b1;
        busy    = 1'b1;
        cnt     = done_dly - 1;
        seen    = 1'b0;
      end else begin
        seen = 1'b1;
      end
    end
  end

  always @(posedge xclk) begin
    cyc <= cyc + 1;
    if (rst_n && mem_req && mem_gnt)
      q.push_back('{mem_we, mem_addr, disp_sel, line_sel});
    if (rst_n && mem_done) done_cyc <= cyc;
    if (host_ack) begin
      ack_cyc <= cyc;
      ack_cnt <= ack_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge xclk);
      if (host_ack) host_req = 1'b0;
    end
  endtask

  task automatic wait_reqs(input int n, input int budget);
    int c = 0;
    while (!(q.size() >= n && !mem_req && !disp_sel) && c < budget) begin
      @(negedge xclk);
      if (host_ack) host_req = 1'b0;
      c++;
    end
    if (c >= budget) chk("timeout", 64'(q.size()), 64'(n));
  endtask

  task automatic pulse_de(input logic [10:0] y);
    de    = 1'b1;
    cnt_y = y;
    @(negedge xclk);
    de = 1'b0;
  endtask

  task automatic chk_line(input string tag, input int qb, input int ln);
    chk({tag, "_n"}, 64'(q.size() - qb), 64'd20);
    if (q.size() >= qb + 20)
      for (int i = 0; i < 20; i++) begin
        chk({tag, "_addr"}, 64'(q[qb+i].addr), 64'(ln * 1024 + i * 32));
        chk({tag, "_disp"}, 64'({q[qb+i].disp, q[qb+i].we}), 64'b10);
        chk({tag, "_ls"}, 64'(q[qb+i].ls), 64'(ln % 2));
      end
  endtask

  initial begin
    int qb, ab, c;
    logic bad;
    rst_n = 1'b0; vsync = 1'b1; de = 1'b0; cnt_y = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0;
    underrun_clr = 1'b0; stray = 1'b0;
    repeat (3) @(negedge xclk);
    chk("rst_req", 64'(mem_req), 64'd0);
    chk("rst_we", 64'(mem_we), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_ack", 64'(host_ack), 64'd0);
    chk("rst_disp", 64'(disp_sel), 64'd0);
    chk("rst_ls", 64'(line_sel), 64'd0);
    chk("rst_und", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    idle(3);
    chk("idle_req", 64'(mem_req), 64'd0);

    // frame start
    qb = q.size(); ab = ack_cnt;
    vsync = 1'b0;
    @(negedge xclk);
    chk("frm_lat1", 64'(mem_req), 64'd0);
    @(negedge xclk);
    chk("frm_lat2", 64'(mem_req), 64'd1);
    wait_reqs(qb + 20, 1000);
    chk_line("frame", qb, 0);
    chk("frame_ack", 64'(ack_cnt - ab), 64'd0);
    vsync = 1'b1;
    idle(2);

    // line fetch, cnt_y=5
    qb = q.size();
    de = 1'b1; cnt_y = 11'd5;
    @(negedge xclk);
    chk("line_lat1", 64'(mem_req), 64'd0);
    de = 1'b0;
    @(negedge xclk);
    chk("line_lat2", 64'(mem_req), 64'd1);
    chk("line_a0", 64'(mem_addr), 64'd6144);
    chk("line_ls0", 64'(line_sel), 64'd0);
    wait_reqs(qb + 20, 1000);
    chk_line("line6", qb, 6);

    // last active line: no fetch
    qb = q.size();
    pulse_de(11'd1023);
    idle(5);
    chk("last_req", 64'({mem_req, disp_sel}), 64'd0);
    chk("last_n", 64'(q.size() - qb), 64'd0);

    // second to last line fetches line 1023
    qb = q.size();
    pulse_de(11'd1022);
    wait_reqs(qb + 20, 1000);
    chk_line("l1023", qb, 1023);

    // frame and line trigger together: frame wins
    qb = q.size();
    vsync = 1'b0; de = 1'b1; cnt_y = 11'd3;
    @(negedge xclk);
    de = 1'b0;
    wait_reqs(qb + 20, 1000);
    chk("both_n", 64'(q.size() - qb), 64'd20);
    chk("both_a0", 64'(q[qb].addr), 64'd0);
    vsync = 1'b1;
    idle(2);

    // host request during display fetch
    qb = q.size(); ab = ack_cnt;
    pulse_de(11'd7);
    idle(3);
    host_req = 1'b1; host_we = 1'b1; host_addr = 24'h123456;
    wait_reqs(qb + 21, 1500);
    idle(12);
    chk("harb_n", 64'(q.size() - qb), 64'd21);
    chk("harb_d0", 64'(q[qb].addr), 64'd8192);
    chk("harb_d19", 64'(q[qb+19].addr), 64'(8192 + 608));
    chk("harb_hwe", 64'(q[qb+20].we), 64'd1);
    chk("harb_hadr", 64'(q[qb+20].addr), 64'h123456);
    chk("harb_hdisp", 64'(q[qb+20].disp), 64'd0);
    chk("harb_ack", 64'(ack_cnt - ab), 64'd1);
    chk("harb_ackt", 64'(ack_cyc - done_cyc), 64'd1);
    chk("harb_hreq", 64'(host_req), 64'd0);

    // host first, then line trigger during H_WAIT
    qb = q.size(); ab = ack_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 24'h000abc;
    @(negedge xclk);
    chk("hf_req", 64'(mem_req), 64'd1);
    chk("hf_addr", 64'(mem_addr), 64'habc);
    chk("hf_we", 64'({mem_we, disp_sel}), 64'd0);
    c = 0;
    while (mem_req && c < 20) begin
      @(negedge xclk);
      c++;
    end
    pulse_de(11'd20);
    wait_reqs(qb + 21, 1500);
    chk("hf_n", 64'(q.size() - qb), 64'd21);
    chk("hf_h0", 64'({q[qb].disp, q[qb].we}), 64'd0);
    chk("hf_h0a", 64'(q[qb].addr), 64'habc);
    chk("hf_d0", 64'(q[qb+1].addr), 64'd21504);
    chk("hf_d0s", 64'(q[qb+1].disp), 64'd1);
    chk("hf_ack", 64'(ack_cnt - ab), 64'd1);

    // deadline overrun
    done_dly = 60;
    qb = q.size();
    pulse_de(11'd9);
    c = 0;
    while (q.size() < qb + 3 && c < 1000) begin
      @(negedge xclk);
      c++;
    end
    chk("und_pre", 64'(underrun), 64'd0);
    pulse_de(11'd10);
    chk("und_set", 64'(underrun), 64'd1);
    wait_reqs(qb + 23, 3000);
    chk("und_n", 64'(q.size() - qb), 64'd23);
    chk("und_q2", 64'(q[qb+2].addr), 64'(10240 + 64));
    chk("und_q3", 64'(q[qb+3].addr), 64'd11264);
    chk("und_ls", 64'(q[qb+3].ls), 64'd1);
    chk("und_q22", 64'(q[qb+22].addr), 64'(11264 + 608));
    chk("und_hold", 64'(underrun), 64'd1);
    underrun_clr = 1'b1;
    @(negedge xclk);
    underrun_clr = 1'b0;
    chk("und_clr", 64'(underrun), 64'd0);
    done_dly = 8;

    // async reset during D_WAIT
    qb = q.size();
    pulse_de(11'd2);
    c = 0;
    while (!(q.size() >= qb + 2 && disp_sel && !mem_req) && c < 500) begin
      @(negedge xclk);
      c++;
    end
    chk("rb_ls", 64'(line_sel), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rb_out", 64'({mem_req, mem_we, disp_sel, line_sel,
                       underrun, host_ack}), 64'd0);
    chk("rb_addr", 64'(mem_addr), 64'd0);
    @(negedge xclk);
    rst_n = 1'b1;
    qb = q.size();
    @(negedge xclk);
    stray = 1'b1;
    @(negedge xclk);
    stray = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      @(negedge xclk);
      bad = bad | mem_req | disp_sel;
    end
    chk("rb_quiet", 64'(bad), 64'd0);
    chk("rb_n", 64'(q.size() - qb), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
